lc3_fetch_ctrl: RTL
===================

Name: lc3_fetch_ctrl

Overview:
Fetch-stage sequencer for the pipelined LC-3.
- Drives the load enables and next-value inputs of the external PC and IR registers. These are plain 16-bit load-enable registers that sample IN when LD is high at the rising edge.
- Runs the instruction-memory request/ready handshake.
- Absorbs decode-stage stalls in a one-entry skid buffer.
- Handles branch/jump redirects, including flushing an in-flight fetch.

Parameters:
- ADDR_W, 16, width of PC, memory address and instruction.
- RESET_PC, 16'h3000, PC value loaded on the first cycle after reset release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low. This is the single clock domain.
- pc_i  in  ADDR_W  current PC register output.
- pc_ld_o  out  1  PC register LD.
- pc_in_o  out  ADDR_W  PC register IN.
- ir_ld_o  out  1  IR register LD.
- ir_in_o  out  ADDR_W  IR register IN.
- mem_req_o  out  1  instruction fetch request.
- mem_addr_o  out  ADDR_W  fetch address.
- mem_rdy_i  in  1  memory ready; mem_data_i is valid in the same cycle.
- mem_data_i  in  ADDR_W  fetched instruction.
- stall_i  in  1  decode not accepting; IR must hold.
- redirect_i  in  1  branch/jump taken; flush fetch.
- redirect_pc_i  in  ADDR_W  target PC.
- de_valid_o  out  1  IR holds a valid, unconsumed instruction.

Behaviour:
- Registered state: st in {INIT, FETCH, HOLD, DRAIN}, skid_q[15:0], addr_q[15:0], de_valid_o. Everything else is combinational from state and inputs, because the LD signals must be valid in the same cycle the PC/IR registers sample them.
- Reset (async, rst_n=0):
  - st=INIT, de_valid_o=0, skid_q=0, addr_q=0.
  - Combinational outputs: mem_req_o=0, ir_ld_o=0.
  - pc_ld_o is 0 while rst_n is low.
- INIT (one cycle after release): pc_ld_o=1, pc_in_o=RESET_PC, mem_req_o=0, next st=FETCH. redirect_i is ignored in INIT.
- FETCH:
  - mem_req_o=1, mem_addr_o=pc_i, addr_q<=pc_i every cycle.
  - Memory protocol: request and address are held until mem_rdy_i; an in-flight request is never abandoned.
  - Priority order for transitions:
    1. redirect_i & mem_rdy_i: pc_ld_o=1, pc_in_o=redirect_pc_i, data discarded, ir_ld_o=0; stay FETCH.
    2. redirect_i & !mem_rdy_i: pc_ld_o=1, pc_in_o=redirect_pc_i; next DRAIN.
    3. mem_rdy_i & !stall_i: ir_ld_o=1, ir_in_o=mem_data_i, pc_ld_o=1, pc_in_o=pc_i+1 (mod 2^16, FFFF->0000); stay FETCH. Zero-wait memory therefore sustains 1 instr/cycle.
    4. mem_rdy_i & stall_i: skid_q<=mem_data_i, pc_ld_o=1, pc_in_o=pc_i+1, ir_ld_o=0; next HOLD.
    5. otherwise: hold; no loads.
- HOLD:
  - mem_req_o=0.
  - redirect_i: pc_ld_o=1 with target, skid discarded; next FETCH.
  - !stall_i: ir_ld_o=1, ir_in_o=skid_q; next FETCH.
  - stall_i: stay HOLD.
- DRAIN:
  - mem_req_o=1, mem_addr_o=addr_q (the old address), ir_ld_o=0.
  - mem_rdy_i: data discarded; next FETCH.
  - A further redirect_i reloads the PC and stays DRAIN (or goes to FETCH if mem_rdy_i is high the same cycle).
- de_valid_o (registered), priority order:
  - redirect_i: next 0.
  - ir_ld_o: next 1.
  - stall_i: hold.
  - otherwise: next 0.
- Default values when not asserted: pc_in_o=pc_i, ir_in_o=mem_data_i.
- Redirect and stall in the same cycle: redirect wins and the IR contents are flushed via de_valid_o.
- Reset asserted mid-request: immediate return to INIT. Memory must tolerate mem_req_o dropping under reset.

Decomposition:
- Package lc3_fetch_pkg holds:
  - fetch_state_t enum (INIT, FETCH, HOLD, DRAIN);
  - LC3_RESET_PC = 16'h3000;
  - LC3_W = 16.
- One natural sub-module: lc3_fetch_skid, the one-entry data buffer with load/valid/clear. Next-state logic, LD/IN muxing and de_valid stay in the top.

Test Plan:
- Reset release, zero-wait memory returning 16'h1111, 16'h2222, no stall.
  - Required: INIT loads PC=3000.
  - Then mem_addr 3000, 3001 on consecutive cycles, ir_ld each cycle with data 1111, 2222.
  - de_valid=1 from the cycle after the first ir_ld.
- stall_i=1 when mem_rdy returns 16'hABCD at PC=3005.
  - Required: PC->3006, no ir_ld, st=HOLD, mem_req=0.
  - stall_i drops: ir_ld with ir_in=ABCD, then fetch resumes at 3006.
- Redirect to 16'h4000 while a request at 3002 is pending (mem_rdy 3 cycles later).
  - Required: PC->4000 immediately, mem_addr stays 3002 until rdy, data discarded, next request at 4000.
  - de_valid cleared the cycle after the redirect.
- redirect_i and mem_rdy_i in the same cycle.
  - Required: no ir_ld, PC=target, no DRAIN; next request at the target address.
- PC=16'hFFFF fetch completes.
  - Required: pc_in_o=16'h0000, next mem_addr=0000.
- rst_n pulsed low in HOLD and in DRAIN.
  - Required: outputs zero asynchronously, de_valid=0.
  - After release: INIT reloads 3000, skid content never reaches the IR.

Source files
------------

// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC-3 fetch stage.
package lc3_fetch_pkg;

  localparam int          LC3_W        = 16;
  localparam logic [15:0] LC3_RESET_PC = 16'h3000;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_skid.sv
// One-entry skid buffer: captures an instruction returned while decode is stalled.
module lc3_fetch_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic [W-1:0] data_reg;
  logic         valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= din;
      valid_reg <= 1'b1;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign dout  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 fetch sequencer: drives external PC/IR load enables, runs the imem
// handshake, parks stalled fetches in a skid entry and handles redirects.
module lc3_fetch_ctrl
  import lc3_fetch_pkg::*;
#(
  parameter int                ADDR_W   = LC3_W,
  parameter logic [ADDR_W-1:0] RESET_PC = LC3_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_ld_o,
  output logic [ADDR_W-1:0] pc_in_o,
  output logic              ir_ld_o,
  output logic [ADDR_W-1:0] ir_in_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rdy_i,
  input  logic [ADDR_W-1:0] mem_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              de_valid_o
);

  fetch_state_t      st_reg, st_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] skid_data;
  logic              skid_valid;
  logic              skid_load, skid_clear;
  logic              de_valid_next;

  lc3_fetch_skid #(.W(ADDR_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (mem_data_i),
    .dout  (skid_data),
    .valid (skid_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_reg <= INIT;
    else        st_reg <= st_next;
  end

  always_comb begin
    st_next = st_reg;
    case (st_reg)
      INIT:  st_next = FETCH;
      FETCH: begin
        if (redirect_i)              st_next = mem_rdy_i ? FETCH : DRAIN;
        else if (mem_rdy_i &&  stall_i) st_next = HOLD;
      end
      HOLD:  if (redirect_i || !stall_i) st_next = FETCH;
      DRAIN: if (mem_rdy_i)              st_next = FETCH;
      default: st_next = INIT;
    endcase
  end

  always_comb begin
    pc_ld_o    = 1'b0;
    pc_in_o    = pc_i;
    ir_ld_o    = 1'b0;
    ir_in_o    = mem_data_i;
    mem_req_o  = 1'b0;
    mem_addr_o = pc_i;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (st_reg)
      // Also the reset state, so gate the PC load while rst_n is low.
      INIT: begin
        pc_ld_o = rst_n;
        pc_in_o = RESET_PC;
      end
      FETCH: begin
        mem_req_o = 1'b1;
        if (redirect_i) begin
          pc_ld_o = 1'b1;
          pc_in_o = redirect_pc_i;
        end else if (mem_rdy_i) begin
          pc_ld_o   = 1'b1;
          pc_in_o   = pc_i + ADDR_W'(1);
          ir_ld_o   = !stall_i;
          skid_load = stall_i;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_ld_o    = 1'b1;
          pc_in_o    = redirect_pc_i;
          skid_clear = 1'b1;
        end else if (!stall_i) begin
          ir_ld_o    = skid_valid;
          ir_in_o    = skid_data;
          skid_clear = 1'b1;
        end
      end
      DRAIN: begin
        // The abandoned request must complete at its original address.
        mem_req_o  = 1'b1;
        mem_addr_o = addr_reg;
        if (redirect_i) begin
          pc_ld_o = 1'b1;
          pc_in_o = redirect_pc_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if (redirect_i)   de_valid_next = 1'b0;
    else if (ir_ld_o) de_valid_next = 1'b1;
    else if (stall_i) de_valid_next = de_valid_o;
    else              de_valid_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      de_valid_o <= 1'b0;
    end else begin
      if (st_reg == FETCH) addr_reg <= pc_i;
      de_valid_o <= de_valid_next;
    end
  end

endmodule
